// File: rtl/es_pkg.sv
// Shared constants and types for the E/S port responder: data/address widths,
// port index names and the output-handshake state encoding.
package es_pkg;

  localparam int ES_DW = 8;
  localparam int ES_AW = 2;

  localparam logic [ES_AW-1:0] PORT_LED  = 2'd0;
  localparam logic [ES_AW-1:0] PORT_DISP = 2'd1;
  localparam logic [ES_AW-1:0] PORT_AUX0 = 2'd2;
  localparam logic [ES_AW-1:0] PORT_AUX1 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } out_state_e;

endpackage

// File: rtl/es_in_fifo.sv
// Synchronous FIFO for producer words; a push is visible at the head one cycle later.
// Head data is combinational (zero when empty); push is ignored when full, pop when empty.
module es_in_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wr_dat_i,
  output logic [DW-1:0] rd_dat_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o   = (cnt_q == FULL_CNT);
  assign empty_o  = (cnt_q == '0);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/es_port_resp.sv
// Peripheral responder for CPU E/S instructions: output port latches with a registered strobe, input FIFO
// with zero-latency head read and a stall on empty read. ES_OUT_ACK_EN holds the strobe until out_ack.
module es_port_resp
  import es_pkg::*;
#(
  parameter int DW         = ES_DW,
  parameter int NPORTS     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_enable,
  input  logic [ES_AW-1:0]     port_addr,
  input  logic [DW-1:0]        wdata,
  input  logic                 rd_en,
  output logic [DW-1:0]        rdata,
  output logic                 stall,
  output logic [NPORTS*DW-1:0] out_data,
  output logic [NPORTS-1:0]    out_strobe,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready
`ifdef ES_OUT_ACK_EN
  ,
  input  logic                 out_ack
`endif
);

  logic                 fifo_empty, fifo_full;
  logic [DW-1:0]        fifo_head;
  logic                 push, pop;
  logic                 rd_stall, ack_stall;
  logic                 addr_ok, wr_take;
  logic [NPORTS-1:0]    sel;
  logic [NPORTS*DW-1:0] data_q, data_d;
  logic [NPORTS-1:0]    strobe_q, strobe_d;

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign pop      = rd_en && !fifo_empty;
  assign rd_stall = rd_en && fifo_empty;
  assign rdata    = fifo_head;
  assign stall    = rd_stall || ack_stall;

  // Addresses beyond the configured port count are dropped without a strobe.
  assign addr_ok  = (32'(port_addr) < NPORTS);
  assign wr_take  = dec_enable && !stall && addr_ok;

  es_in_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (push),
    .pop_i    (pop),
    .wr_dat_i (in_data),
    .rd_dat_o (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    sel    = '0;
    data_d = data_q;
    for (int k = 0; k < NPORTS; k++) begin
      if (32'(port_addr) == k) sel[k] = 1'b1;
    end
    for (int k = 0; k < NPORTS; k++) begin
      if (wr_take && sel[k]) data_d[k*DW +: DW] = wdata;
    end
  end

`ifdef ES_OUT_ACK_EN
  out_state_e state_q, state_d;

  // A new write while waiting for the consumer is held off via stall.
  assign ack_stall = (state_q == WAIT) && dec_enable;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    strobe_d = '0;
    case (state_q)
      IDLE: begin
        if (wr_take) begin
          state_d  = WAIT;
          strobe_d = sel;
        end
      end
      WAIT: begin
        if (out_ack) state_d  = IDLE;
        else         strobe_d = strobe_q;
      end
      default: state_d = IDLE;
    endcase
  end
`else
  assign ack_stall = 1'b0;
  assign strobe_d  = wr_take ? sel : '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= '0;
      strobe_q <= '0;
    end else begin
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign out_data   = data_q;
  assign out_strobe = strobe_q;

endmodule

// File: doc/es_port_resp.md
Name: es_port_resp

Overview:
- I/O responder on the peripheral side of the CPU's E/S instructions.
- Accepts CPU output writes: `dec_enable` strobe, 2-bit port address, 8-bit data already muxed register/immediate by the datapath. Latches them into one of NPORTS output registers and pulses a per-port strobe.
- Accepts words from an external producer through a valid/ready handshake into a small FIFO. Supplies them to the CPU input instruction (`s_epe`).
- Raises `stall` so the control unit can hold the PC when an input is requested and none is available.

Parameters:
- DW, 8, data width of all ports.
- NPORTS, 4, number of output ports; must be a power of two, ≤ 4.
- FIFO_DEPTH, 2, input FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- dec_enable  in  1  CPU output-write strobe, one cycle per instruction
- port_addr  in  2  output port select (instruction field)
- wdata  in  DW  output data from the datapath
- rd_en  in  1  CPU input request (`s_epe`)
- rdata  out  DW  input word to the register file write port
- stall  out  1  CPU must hold PC and suppress `we3` this cycle
- out_data  out  NPORTS*DW  output port registers; port k occupies bits [k*DW +: DW]
- out_strobe  out  NPORTS  one-cycle pulse on the port just written
- in_data  in  DW  external producer data
- in_valid  in  1  producer has a word
- in_ready  out  1  FIFO can accept a word

Behaviour:
- **Reset values:** `out_data` = 0, `out_strobe` = 0, FIFO empty, `in_ready` = 1, `rdata` = 0, `stall` = 0. Reset overrides every other event in the same cycle, including an in-flight transfer.

**Output path:**
- `dec_enable` = 1 and `stall` = 0: `out_data[port_addr]` <= `wdata` at the clock edge.
- `out_strobe[port_addr]` is 1 for exactly the next cycle (registered pulse).
- Other ports are unchanged.
- `port_addr` ≥ NPORTS: the write is ignored, with no strobe.
- Back-to-back writes to the same port produce consecutive strobes; the last write wins.

**Input FIFO:**
- Push when `in_valid` and `in_ready` are both 1.
- `in_ready` = !full (combinational from registered count).
- Pop when `rd_en` = 1 and the FIFO is not empty.
- `rdata` = head entry, combinational, valid in the same cycle as the pop. The CPU writes it in that cycle.
- **Empty read:** `rd_en` = 1 while empty gives `stall` = 1 and `rdata` = 0, with no pop. `stall` stays high every cycle until a word arrives. The first cycle that shows non-empty pops and drops `stall`.
- **Push-through:** a word pushed in cycle N is poppable in cycle N+1; there is no bypass.
- **Simultaneous push and pop:** when full, pop frees space, but `in_ready` was already 0 that cycle, so no push occurs. When neither full nor empty, both happen and the count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits.

**Stall sources:** empty read, and the optional ack wait described below.

Optional Feature:
- **Macro:** ES_OUT_ACK_EN.
- **When defined:** adds input `out_ack` (1 bit) and a per-block output state machine:
  - IDLE → write accepted → WAIT.
  - WAIT: `stall` = 1 on any new `dec_enable` (the write is not taken); `out_strobe` stays high on the written port until `out_ack`.
  - WAIT → IDLE on `out_ack`. The next write is accepted the cycle after.
  - `out_ack` in IDLE is ignored.
  - Reset → IDLE.
- **When not defined:** no `out_ack` port and no WAIT state; strobe is a single-cycle pulse, as above.

Decomposition:
- Shared package `es_pkg`: DW default, port address width, port index constants PORT_LED=0, PORT_DISP=1, PORT_AUX0=2, PORT_AUX1=3, and the output FSM state enum (IDLE, WAIT).
- One sub-module `es_in_fifo` (sync FIFO: push/pop, full/empty, head data). The output latch logic stays in the top.

Test Plan:
- **Reset:** assert reset during a pending write with `dec_enable` = 1, `wdata` = 0xAA → all `out_data` = 0, `out_strobe` = 0, `in_ready` = 1 the cycle after.
- **Output writes:**
  - Write 0x5C to port 2 → `out_data[23:16]` = 0x5C, `out_strobe` = 4'b0100 for one cycle, other ports 0.
  - Write to port 2 then port 2 again with 0x11 → two strobes, final value 0x11.
- **Input FIFO fill:**
  - Push 0x01, 0x02 with `rd_en` = 0 → `in_ready` falls to 0 after the second push.
  - Third `in_valid` word 0x03 is held by the producer.
  - `rd_en` → `rdata` = 0x01, next `rdata` = 0x02 (FIFO order), then 0x03 accepted.
- **Empty read stall:** `rd_en` = 1 with FIFO empty for 3 cycles → `stall` = 1 for those cycles. Push 0x7E → the next cycle gives `rdata` = 0x7E, `stall` = 0.
- **Concurrent push/pop at count 1 (depth 2):** count stays 1 over 8 cycles; the data sequence is preserved; no loss.
- **ES_OUT_ACK_EN:**
  - Write port 0, then a second write the next cycle → `stall` = 1 and port 0 strobe held.
  - `out_ack` after 4 cycles → IDLE; the second write is accepted the following cycle.
